// File: rtl/gpio_wr_capture.sv
// rtl/gpio_wr_capture.sv - synchronised GPIO write-strobe capture into a FWFT FIFO
module gpio_wr_capture #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       wr_strobe,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [SYNC_STAGES-1:0] primed;
    logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
    logic                   strobe_d;
    logic                   armed;

    logic                   sync_strobe;
    logic [DATA_W-1:0]      sync_data;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   do_push;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    assign sync_strobe = strobe_sync[SYNC_STAGES-1];
    assign sync_data   = data_sync[SYNC_STAGES-1];

    // primed marks when the chain output reflects the pad rather than reset
    // zeros; armed then requires a genuine low before any edge is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync <= '0;
            primed      <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            strobe_d    <= 1'b0;
            armed       <= 1'b0;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], wr_strobe};
            primed      <= {primed[SYNC_STAGES-2:0], 1'b1};
            data_sync[0] <= wr_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            strobe_d    <= sync_strobe;
            if (primed[SYNC_STAGES-1] && !sync_strobe) armed <= 1'b1;
        end
    end

    assign push    = sync_strobe & ~strobe_d & armed & ena;
    assign full    = (fifo_count == CW'(DEPTH));
    assign pop     = out_valid & out_ready;
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= sync_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10: begin
                    fifo_count <= fifo_count + CW'(1);
                    out_valid  <= 1'b1;
                end
                2'b01: begin
                    fifo_count <= fifo_count - CW'(1);
                    out_valid  <= (fifo_count != CW'(1));
                end
                default: ;
            endcase
            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (push && full && !pop) overflow <= 1'b1;
            else if (clear_ovf)       overflow <= 1'b0;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule
